// File: rtl/seg_scan_if.sv
// Bundle between result logic and the 7-segment scan controller: data/load
// inputs toward the controller, decoder/anode drive back out.
interface seg_scan_if;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp_en;
  logic        lz_en;
  logic [3:0]  bcd;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;

  // load is a one-cycle strobe with no ready: the controller always accepts it.
  modport master (
    output value, load, dp_en, lz_en,
    input  bcd, dp, an, frame_tick
  );

  modport slave (
    input  value, load, dp_en, lz_en,
    output bcd, dp, an, frame_tick
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// 4-digit common-anode 7-segment scan controller with double-buffered BCD
// value, per-slot blanking, leading-zero suppression and decimal points.
module seg_scan_ctrl #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       rst,
  seg_scan_if.slave  bus
);
  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    dig_q, dig_d;
  logic [15:0]   sh_val_q, sh_val_d;
  logic [3:0]    sh_dp_q, sh_dp_d;
  logic          pend_q, pend_d;
  logic [15:0]   act_val_q, act_val_d;
  logic [3:0]    act_dp_q, act_dp_d;
  logic [3:0]    an_q, an_d;
  logic [3:0]    bcd_q, bcd_d;
  logic          dp_q, dp_d;
  logic          ft_q, ft_d;

  logic slot_end, frame_end, upper_zero, supp, on_phase;

  // Outputs are computed from the next-state values so the registered
  // outputs line up with the (digit, cnt, active) state of the same cycle.
  always_comb begin
    slot_end  = (cnt_q == CNT_LAST);
    frame_end = slot_end && (dig_q == 2'd3);
    cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
    dig_d     = slot_end ? dig_q + 2'd1 : dig_q;

    act_val_d = act_val_q;
    act_dp_d  = act_dp_q;
    pend_d    = pend_q;
    if (frame_end && pend_q) begin
      act_val_d = sh_val_q;
      act_dp_d  = sh_dp_q;
      pend_d    = 1'b0;
    end

    // A load on the transfer edge lands in shadow and waits one more frame.
    sh_val_d = sh_val_q;
    sh_dp_d  = sh_dp_q;
    if (bus.load) begin
      sh_val_d = bus.value;
      sh_dp_d  = bus.dp_en;
      pend_d   = 1'b1;
    end

    upper_zero = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i >= int'(dig_d) && act_val_d[4*i +: 4] != 4'h0) upper_zero = 1'b0;
    end
    supp     = bus.lz_en && (dig_d != 2'd0) && upper_zero;
    on_phase = (cnt_d >= CNT_BLANK);

    an_d  = 4'hF;
    if (on_phase && !supp) an_d[dig_d] = 1'b0;
    bcd_d = act_val_d[{dig_d, 2'b00} +: 4];
    dp_d  = on_phase ? ~act_dp_d[dig_d] : 1'b1;
    ft_d  = frame_end;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      dig_q     <= 2'd0;
      sh_val_q  <= 16'h0;
      sh_dp_q   <= 4'h0;
      pend_q    <= 1'b0;
      act_val_q <= 16'h0;
      act_dp_q  <= 4'h0;
      an_q      <= 4'hF;
      bcd_q     <= 4'h0;
      dp_q      <= 1'b1;
      ft_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      dig_q     <= dig_d;
      sh_val_q  <= sh_val_d;
      sh_dp_q   <= sh_dp_d;
      pend_q    <= pend_d;
      act_val_q <= act_val_d;
      act_dp_q  <= act_dp_d;
      an_q      <= an_d;
      bcd_q     <= bcd_d;
      dp_q      <= dp_d;
      ft_q      <= ft_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.bcd        = bcd_q;
  assign bus.dp         = dp_q;
  assign bus.frame_tick = ft_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with REFRESH_DIV=8, BLANK_CYCLES=2:
// directed scenarios followed by random loads, lz_en toggles and a reset.
module tb_seg_scan_ctrl;
  localparam int RD = 8;
  localparam int BL = 2;
  localparam int FRAME = 4 * RD;
  localparam logic [9:0] RESET_EXP = {4'hF, 4'h0, 1'b1, 1'b0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  seg_scan_if bus();

  seg_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYCLES(BL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: cycle index since reset release plus the buffers.
  int          m_cyc = 0;
  logic [15:0] m_act_val = 16'h0, m_sh_val = 16'h0;
  logic [3:0]  m_act_dp = 4'h0, m_sh_dp = 4'h0;
  bit          m_pend = 1'b0;
  logic [9:0]  exp_q[$];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", tag, obs, exp, m_cyc, $time);
    end
  endtask

  function automatic logic [9:0] model_out(input bit lz);
    int d, c;
    logic [15:0] upper;
    logic [3:0] an;
    logic [3:0] nib;
    bit supp, on, dp, ft;
    d     = (m_cyc / RD) % 4;
    c     = m_cyc % RD;
    upper = m_act_val >> (4 * d);
    nib   = upper[3:0];
    supp  = lz && (d > 0) && (upper == 16'h0);
    on    = (c >= BL);
    an    = 4'hF;
    if (on && !supp) an[d] = 1'b0;
    dp    = on ? ~m_act_dp[d] : 1'b1;
    ft    = (m_cyc > 0) && (m_cyc % FRAME == 0);
    return {an, nib, dp, ft};
  endfunction

  task automatic model_step();
    if (rst) begin
      m_act_val = 16'h0; m_act_dp = 4'h0;
      m_sh_val  = 16'h0; m_sh_dp  = 4'h0;
      m_pend    = 1'b0;
      m_cyc     = 0;
    end else begin
      if ((m_cyc % FRAME == FRAME - 1) && m_pend) begin
        m_act_val = m_sh_val;
        m_act_dp  = m_sh_dp;
        m_pend    = 1'b0;
      end
      if (bus.load) begin
        m_sh_val = bus.value;
        m_sh_dp  = bus.dp_en;
        m_pend   = 1'b1;
      end
      m_cyc++;
    end
    exp_q.push_back(model_out(bus.lz_en));
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Scoreboard: compare DUT outputs mid-cycle against the model.
  initial forever begin
    logic [9:0] e;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rst) e = RESET_EXP;
      check("an",         16'(bus.an),         16'(e[9:6]));
      check("bcd",        16'(bus.bcd),        16'(e[5:2]));
      check("dp",         16'(bus.dp),         16'(e[1]));
      check("frame_tick", 16'(bus.frame_tick), 16'(e[0]));
      check("an_onehot",  16'($countones(~bus.an) > 1), 16'(0));
    end
  end

  task automatic wait_cycle(input int n);
    int guard = 0;
    while (m_cyc != n && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (m_cyc != n) check("wait_cycle_timeout", 16'(m_cyc), 16'(n));
  endtask

  task automatic load_at(input int n, input logic [15:0] v, input logic [3:0] dpe);
    wait_cycle(n);
    bus.value = v;
    bus.dp_en = dpe;
    bus.load  = 1'b1;
    @(posedge clk); #1;
    bus.load  = 1'b0;
  endtask

  task automatic pulse_rst_at(input int n);
    wait_cycle(n);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    for (int i = 0; i < 4; i++)
      v[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
    return v;
  endfunction

  initial begin
    bus.value = 16'h0;
    bus.load  = 1'b0;
    bus.dp_en = 4'h0;
    bus.lz_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Idle frame, then a plain load with a decimal point on digit 2.
    load_at(5, 16'h1234, 4'b0100);
    wait_cycle(64);

    // Leading-zero blanking.
    bus.lz_en = 1'b1;
    load_at(70, 16'h0070, 4'h0);
    load_at(130, 16'h0000, 4'h0);
    wait_cycle(192);
    bus.lz_en = 1'b0;

    // Load on the frame-boundary cycle while a transfer is pending.
    load_at(192 + 20, 16'hAAAA, 4'h0);
    load_at(192 + 31, 16'h5555, 4'h0);
    wait_cycle(300);

    // Reset mid-slot (digit 2, cnt 4) after a transfer.
    load_at(300, 16'h9999, 4'hF);
    pulse_rst_at(320 + 2 * RD + 4);
    wait_cycle(100);

    for (int k = 0; k < 700; k++) begin
      if ($urandom_range(0, 11) == 0) begin
        bus.load  = 1'b1;
        bus.value = rand_bcd();
        bus.dp_en = 4'($urandom_range(0, 15));
      end else begin
        bus.load  = 1'b0;
      end
      if ($urandom_range(0, 49) == 0) bus.lz_en = ~bus.lz_en;
      rst = (k == 350);
      @(posedge clk); #1;
    end
    bus.load = 1'b0;
    rst      = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
